// File: rtl/json_arb_pkg.sv
// Shared types and default sizing for the JSON test arbiter.
// Requester slots are ordered by test class: LITERAL, STRING, NUMBER, ARRAY, OBJECT.
package json_arb_pkg;

  localparam int DEF_NUM_REQ = 5;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    REPORT
  } arb_state_t;

  typedef enum logic [2:0] {
    LITERAL,
    STRING,
    NUMBER,
    ARRAY,
    OBJECT
  } req_id_t;

endpackage

// File: rtl/json_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
// Returns a one-hot grant, its index and whether any request was found.
module json_rr_pick #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/json_test_arbiter.sv
// Arbitrates JSON test requesters onto one shared parser engine, waits for its
// verdict (or a timeout), reports each test and keeps per-requester tallies.
module json_test_arbiter
  import json_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  output logic [NUM_REQ-1:0]           gnt,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            eng_data,
  output logic                         eng_valid,
  output logic                         eng_last,
  input  logic                         eng_ready,
  input  logic                         eng_done,
  input  logic                         eng_pass,
  output logic                         res_valid,
  output logic                         res_pass,
  output logic                         res_timeout,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  input  logic [$clog2(NUM_REQ)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]             cnt_pass,
  output logic [CNT_W-1:0]             cnt_fail,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT) + 1;

  arb_state_t          state;
  logic [IW-1:0]       g_idx;
  logic [IW-1:0]       rr_ptr;
  logic [TW-1:0]       timer;
  logic [CNT_W-1:0]    pass_cnt [NUM_REQ];
  logic [CNT_W-1:0]    fail_cnt [NUM_REQ];

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;

  json_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Handshake: a byte moves to the engine on a cycle where eng_valid and
  // eng_ready are both high; the granted requester sees that as req_valid & req_ready.
  assign eng_data  = req_data[g_idx*DATA_W +: DATA_W];
  assign eng_valid = (state == STREAM) && req_valid[g_idx];
  assign eng_last  = (state == STREAM) && req_last[g_idx];
  assign req_ready = ((state == STREAM) && eng_ready) ? gnt : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    cnt_pass = '0;
    cnt_fail = '0;
    if (int'(cnt_sel) < NUM_REQ) begin
      cnt_pass = pass_cnt[cnt_sel];
      cnt_fail = fail_cnt[cnt_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      g_idx       <= '0;
      rr_ptr      <= '0;
      timer       <= '0;
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      res_timeout <= 1'b0;
      res_id      <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pass_cnt[i] <= '0;
        fail_cnt[i] <= '0;
      end
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_gnt;
            g_idx <= pick_idx;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (eng_valid && eng_ready && eng_last) begin
            timer <= '0;
            state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // A verdict arriving on the timeout cycle still counts as a verdict.
          if (eng_done || timer == TW'(TIMEOUT - 1)) begin
            res_valid   <= 1'b1;
            res_id      <= g_idx;
            res_pass    <= eng_done && eng_pass;
            res_timeout <= !eng_done;
            if (eng_done && eng_pass) begin
              if (!(&pass_cnt[g_idx])) pass_cnt[g_idx] <= pass_cnt[g_idx] + CNT_W'(1);
            end else begin
              if (!(&fail_cnt[g_idx])) fail_cnt[g_idx] <= fail_cnt[g_idx] + CNT_W'(1);
            end
            state <= REPORT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REPORT: begin
          gnt    <= '0;
          rr_ptr <= (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_json_test_arbiter.sv
// Bench for json_test_arbiter: drives requesters and a scripted engine, and
// checks engine bytes and test reports against expected queues.
module tb_json_test_arbiter;
  import json_arb_pkg::*;

  localparam int NREQ = 5;
  localparam int DW   = 8;
  localparam int CW   = 3;
  localparam int TO   = 16;
  localparam int IW   = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [DW-1:0]     eng_data;
  logic              eng_valid;
  logic              eng_last;
  logic              eng_ready;
  logic              eng_done;
  logic              eng_pass;
  logic              res_valid;
  logic              res_pass;
  logic              res_timeout;
  logic [IW-1:0]     res_id;
  logic [IW-1:0]     cnt_sel;
  logic [CW-1:0]     cnt_pass;
  logic [CW-1:0]     cnt_fail;
  logic              busy;

  json_test_arbiter #(.NUM_REQ(NREQ), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .req_data(req_data),
    .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .eng_data(eng_data), .eng_valid(eng_valid), .eng_last(eng_last),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_pass(eng_pass),
    .res_valid(res_valid), .res_pass(res_pass), .res_timeout(res_timeout),
    .res_id(res_id), .cnt_sel(cnt_sel), .cnt_pass(cnt_pass),
    .cnt_fail(cnt_fail), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pass [NREQ];
  int exp_fail [NREQ];

  logic [4:0]    exp_q  [$];
  logic [DW:0]   byte_q [$];
  logic [4:0]    res_e;
  logic [DW:0]   byte_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && eng_valid && eng_ready) begin
      if (byte_q.size() == 0) check("byte_unexp", 1, 0);
      else begin
        byte_e = byte_q.pop_front();
        check("eng_byte", {eng_last, eng_data}, byte_e);
        check("req_ready", req_ready, gnt);
      end
    end
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) check("res_unexp", 1, 0);
      else begin
        res_e = exp_q.pop_front();
        check("res", {res_id, res_pass, res_timeout}, res_e);
      end
    end
  end

  task automatic check_counters();
    for (int i = 0; i < NREQ; i++) begin
      cnt_sel = IW'(i);
      #1;
      check("cnt_pass", cnt_pass, exp_pass[i]);
      check("cnt_fail", cnt_fail, exp_fail[i]);
    end
  endtask

  // Driver: present one byte on lane id (other lanes carry noise), optionally stall the engine.
  task automatic send_byte(input int id, input logic last, input bit stall);
    logic [DW-1:0] d;
    int cyc;
    d = DW'($urandom_range(0, 255));
    for (int l = 0; l < NREQ; l++) req_data[l*DW +: DW] = DW'($urandom_range(0, 255));
    req_data[id*DW +: DW] = d;
    req_valid = '1;
    req_last = '0;
    req_last[id] = last;
    byte_q.push_back({last, d});
    if (stall) begin
      eng_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        check("stall_rdy", req_ready, 0);
        eng_done = (s == 1);
        eng_pass = 1'b1;
      end
      eng_done = 1'b0;
      @(posedge clk); #1;
      eng_ready = 1'b1;
    end
    #1;
    cyc = 0;
    while (!(req_ready[id] && eng_valid) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("hs_wait", cyc < 50, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input int id);
    int cyc;
    cyc = 0;
    while (gnt == 0 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("gnt", gnt, 1 << id);
    check("busy", busy, 1);
  endtask

  // mode 0: pass, 1: fail, 2: timeout, 3: verdict on the timeout cycle (pass)
  task automatic do_test(input int id, input int nbytes, input int mode, input int stall_at, input bit drop);
    int cyc;
    int done_at;
    int exp_lat;
    logic ok_pass;
    ok_pass = (mode == 0 || mode == 3);
    exp_q.push_back({3'(id), ok_pass, mode == 2});
    wait_gnt(id);
    if (drop) req[id] = 1'b0;
    for (int k = 0; k < nbytes; k++) send_byte(id, k == nbytes - 1, k == stall_at);
    req_valid = '0;
    req_last  = '0;
    done_at = (mode == 2) ? -1 : (mode == 3 ? 15 : 2);
    exp_lat = (mode == 2) ? TO : done_at + 1;
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      if (cyc == done_at) begin
        eng_done = 1'b1;
        eng_pass = ok_pass;
      end
      @(posedge clk); #1;
      eng_done = 1'b0;
      cyc++;
    end
    check("res_lat", cyc, exp_lat);
    @(posedge clk); #1;
    check("gnt_clr", gnt, 0);
    check("idle", busy, 0);
    check("res_pulse", res_valid, 0);
    if (ok_pass) begin
      if (exp_pass[id] < 7) exp_pass[id]++;
    end else begin
      if (exp_fail[id] < 7) exp_fail[id]++;
    end
    cnt_sel = IW'(id);
    #1;
    check("cnt_pass_id", cnt_pass, exp_pass[id]);
    check("cnt_fail_id", cnt_fail, exp_fail[id]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      exp_pass[i] = 0;
      exp_fail[i] = 0;
    end
  endtask

  int seen;

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; req_valid = '0; req_last = '0;
    eng_ready = 1'b1; eng_done = 1'b0; eng_pass = 1'b0; cnt_sel = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_bits", {res_id, res_pass, res_timeout}, 0);
    check("rst_eng_valid", eng_valid, 0);
    rst_n = 1'b1;
    check_counters();

    // All requesters held: strict rotation from pointer 0.
    req = '1;
    for (int t = 0; t < 6; t++) do_test(t % NREQ, 3, 0, -1, 0);
    // Pointer now 1: wrap to OBJECT, then LITERAL.
    req = 5'b10001;
    do_test(OBJECT, 3, 1, -1, 0);
    do_test(LITERAL, 2, 0, -1, 0);
    req = '0;

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    check_counters();

    req[NUMBER] = 1'b1;
    do_test(NUMBER, 3, 0, -1, 1);
    req[STRING] = 1'b1;
    do_test(STRING, 5, 1, 2, 1);
    req[ARRAY] = 1'b1;
    do_test(ARRAY, 2, 2, -1, 1);
    req[ARRAY] = 1'b1;
    do_test(ARRAY, 2, 3, -1, 1);
    for (int t = 0; t < 8; t++) begin
      req[LITERAL] = 1'b1;
      do_test(LITERAL, 1, 1, -1, 1);
    end
    check_counters();

    for (int s = NREQ; s < 8; s++) begin
      cnt_sel = IW'(s);
      #1;
      check("cnt_oor_pass", cnt_pass, 0);
      check("cnt_oor_fail", cnt_fail, 0);
    end

    // Reset in the middle of a stream: test is dropped without a report.
    req[OBJECT] = 1'b1;
    wait_gnt(OBJECT);
    req = '0;
    send_byte(OBJECT, 1'b0, 1'b0);
    send_byte(OBJECT, 1'b0, 1'b0);
    req_valid = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_gnt", gnt, 0);
    check("mrst_res_valid", res_valid, 0);
    check("mrst_eng_valid", eng_valid, 0);
    clear_model();
    check_counters();
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    check("mrst_no_report", seen, 0);

    check("exp_q_empty", exp_q.size(), 0);
    check("byte_q_empty", byte_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
